corefft_inbuf_wr_ctrl: RTL and testbench



---
 rtl/corefft_inbuf_wr_ctrl.sv | 126 ++++++++++++
 tb/tb_corefft_inbuf_wr_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/corefft_inbuf_wr_ctrl.sv
// rtl/corefft_inbuf_wr_ctrl.sv - FFT input buffer write controller (stream to 512x64 LSRAM)
module corefft_inbuf_wr_ctrl #(
    parameter int LOG2N    = 9,
    parameter bit BITREV   = 1'b1,
    parameter bit SOF_SYNC = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DATAI_VALID,
    input  logic [31:0] DATAI_RE,
    input  logic [31:0] DATAI_IM,
    input  logic        DATAI_SOF,
    output logic        DATAI_READY,
    input  logic        BUF_RELEASE,
    output logic [63:0] DI,
    output logic [8:0]  WADDR,
    output logic        WRB,
    output logic        FRAME_RDY,
    output logic        SOF_ERR
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [LOG2N-1:0] CNT_ZERO = '0;
    localparam logic [LOG2N-1:0] CNT_ONE  = 1;
    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  cnt_q, cnt_d;
    logic [63:0]       di_q, di_d;
    logic [8:0]        waddr_q, waddr_d;
    logic              wrb_q, wrb_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              sof_err_q, sof_err_d;

    logic              accept;
    logic              discard;
    logic              restart;
    logic [8:0]        cnt_addr;

    assign accept  = DATAI_VALID && (state_q == ST_FILL);
    assign discard = (cnt_q == CNT_ZERO) && SOF_SYNC && !DATAI_SOF;
    assign restart = (cnt_q != CNT_ZERO) && DATAI_SOF;

    // Buffer address for the current sample: natural or bit-reversed within LOG2N bits, upper bits zero
    always_comb begin
        cnt_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            cnt_addr[i] = BITREV ? cnt_q[LOG2N-1-i] : cnt_q[i];
        end
    end

    // Next-state, counter and registered write-port values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        di_d        = di_q;
        waddr_d     = waddr_q;
        wrb_d       = 1'b0;
        frame_rdy_d = 1'b0;
        sof_err_d   = sof_err_q;
        case (state_q)
            ST_FILL: begin
                if (accept && !discard) begin
                    wrb_d = 1'b1;
                    di_d  = {DATAI_IM, DATAI_RE};
                    if (restart) begin
                        // Mid-frame SOF: start over at position 0; stale words get overwritten
                        waddr_d   = '0;
                        cnt_d     = CNT_ONE;
                        sof_err_d = 1'b1;
                    end else begin
                        waddr_d = cnt_addr;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_FULL;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
            end
            ST_FULL: begin
                // FRAME_RDY lags entry to FULL by one cycle so the final write has landed
                if (BUF_RELEASE) begin
                    state_d = ST_FILL;
                end else begin
                    frame_rdy_d = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_FILL;
            cnt_q       <= CNT_ZERO;
            di_q        <= '0;
            waddr_q     <= '0;
            wrb_q       <= 1'b0;
            frame_rdy_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            di_q        <= di_d;
            waddr_q     <= waddr_d;
            wrb_q       <= wrb_d;
            frame_rdy_q <= frame_rdy_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign DATAI_READY = (state_q == ST_FILL);
    assign DI          = di_q;
    assign WADDR       = waddr_q;
    assign WRB         = wrb_q;
    assign FRAME_RDY   = frame_rdy_q;
    assign SOF_ERR     = sof_err_q;

endmodule

// File: tb/tb_corefft_inbuf_wr_ctrl.sv
// tb/tb_corefft_inbuf_wr_ctrl.sv - directed-vector bench for corefft_inbuf_wr_ctrl
module tb_corefft_inbuf_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 1'b0, a_sof = 1'b0, a_rel = 1'b0;
    logic [31:0] a_re = '0, a_im = '0;
    logic        a_ready, a_wrb, a_frdy, a_serr;
    logic [63:0] a_di;
    logic [8:0]  a_waddr;

    logic        b_valid = 1'b0, b_sof = 1'b0, b_rel = 1'b0;
    logic [31:0] b_re = '0, b_im = '0;
    logic        b_ready, b_wrb, b_frdy, b_serr;
    logic [63:0] b_di;
    logic [8:0]  b_waddr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    corefft_inbuf_wr_ctrl u_dut_a (
        .CLK(clk), .RST(rst), .DATAI_VALID(a_valid), .DATAI_RE(a_re), .DATAI_IM(a_im),
        .DATAI_SOF(a_sof), .DATAI_READY(a_ready), .BUF_RELEASE(a_rel), .DI(a_di),
        .WADDR(a_waddr), .WRB(a_wrb), .FRAME_RDY(a_frdy), .SOF_ERR(a_serr)
    );

    corefft_inbuf_wr_ctrl #(.LOG2N(4), .BITREV(1'b0), .SOF_SYNC(1'b1)) u_dut_b (
        .CLK(clk), .RST(rst), .DATAI_VALID(b_valid), .DATAI_RE(b_re), .DATAI_IM(b_im),
        .DATAI_SOF(b_sof), .DATAI_READY(b_ready), .BUF_RELEASE(b_rel), .DI(b_di),
        .WADDR(b_waddr), .WRB(b_wrb), .FRAME_RDY(b_frdy), .SOF_ERR(b_serr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] bitrev9(input logic [8:0] k);
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[i] = k[8-i];
        return r;
    endfunction

    // Drive DUT A for one cycle; returns #1 after the following falling edge
    task automatic a_cycle(input logic v, input logic s, input logic [31:0] re, input logic [31:0] im);
        a_valid = v; a_sof = s; a_re = re; a_im = im;
        @(negedge clk); #1;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_ready"}, 64'(a_ready), 64'd1);
        check({tag, "_di"},    a_di,          64'd0);
        check({tag, "_waddr"}, 64'(a_waddr), 64'd0);
        check({tag, "_wrb"},   64'(a_wrb),   64'd0);
        check({tag, "_frdy"},  64'(a_frdy),  64'd0);
        check({tag, "_serr"},  64'(a_serr),  64'd0);
    endtask

    initial begin
        int errs;
        int seen [512];
        logic [31:0] kv;
        int wcnt, s, bad_addr, bad_data, bad_hi;

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        check_a_reset("por");
        rst = 1'b0;

        // Reset mid-stream while WRB is high
        a_cycle(1'b1, 1'b1, 32'd5, 32'd6);
        check("mid_wrb0", 64'(a_wrb), 64'd1);
        a_cycle(1'b1, 1'b0, 32'd7, 32'd8);
        check("mid_waddr1", 64'(a_waddr), 64'd256);
        rst = 1'b1; a_valid = 1'b0;
        #1;
        check_a_reset("midrst");
        @(negedge clk); #1;
        rst = 1'b0;

        // Bit-reversed 512-point frame, sample k = {k, ~k}
        foreach (seen[i]) seen[i] = 0;
        errs = 0;
        for (int k = 0; k < 512; k++) begin
            kv = 32'(k);
            a_cycle(1'b1, k == 0, ~kv, kv);
            if (a_wrb !== 1'b1 || a_waddr !== bitrev9(9'(k)) || a_di !== {kv, ~kv}) errs++;
            if (a_wrb === 1'b1) seen[a_waddr]++;
            if (k == 0)   check("br_s0_addr",   64'(a_waddr), 64'd0);
            if (k == 1)   check("br_s1_addr",   64'(a_waddr), 64'd256);
            if (k == 3)   check("br_s3_addr",   64'(a_waddr), 64'd384);
            if (k == 511) check("br_s511_addr", 64'(a_waddr), 64'd511);
            if (k == 511) check("br_s511_di",   a_di, {32'd511, ~32'd511});
            if (k == 510) check("br_ready_k510", 64'(a_ready), 64'd1);
        end
        check("br_per_sample", 64'(errs), 64'd0);
        errs = 0;
        foreach (seen[i]) if (seen[i] != 1) errs++;
        check("br_once_each", 64'(errs), 64'd0);
        check("br_ready_drop", 64'(a_ready), 64'd0);
        check("br_frdy_early", 64'(a_frdy), 64'd0);

        // Back-pressure: valid held in FULL for 100 cycles
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            a_cycle(1'b1, 1'b1, 32'hAAAA0000, 32'h5555FFFF);
            if (c == 0) check("br_frdy_rise", 64'(a_frdy), 64'd1);
            if (a_wrb !== 1'b0 || a_ready !== 1'b0 || a_frdy !== 1'b1) errs++;
        end
        check("bp_hold", 64'(errs), 64'd0);
        a_rel = 1'b1;
        a_cycle(1'b1, 1'b1, 32'h11111111, 32'h22222222);
        a_rel = 1'b0;
        check("rel_frdy", 64'(a_frdy), 64'd0);
        check("rel_ready", 64'(a_ready), 64'd1);
        check("rel_nowrite", 64'(a_wrb), 64'd0);

        // New frame: SOF at position 0, then SOF again on the 10th accept
        a_cycle(1'b1, 1'b1, 32'h11111111, 32'h22222222);
        check("rel_first_wrb", 64'(a_wrb), 64'd1);
        check("rel_first_addr", 64'(a_waddr), 64'd0);
        check("rel_first_di", a_di, 64'h22222222_11111111);
        for (int k = 1; k < 9; k++) a_cycle(1'b1, 1'b0, 32'(k), 32'(k));
        check("sof_err_pre", 64'(a_serr), 64'd0);
        a_cycle(1'b1, 1'b1, 32'hC0DE, 32'hBEEF);
        check("sof_err_set", 64'(a_serr), 64'd1);
        check("sof_restart_addr", 64'(a_waddr), 64'd0);
        check("sof_restart_di", a_di, 64'h0000BEEF_0000C0DE);
        a_cycle(1'b1, 1'b0, 32'd1, 32'd1);
        check("sof_next_addr", 64'(a_waddr), 64'd256);
        for (int k = 2; k < 511; k++) a_cycle(1'b1, 1'b0, 32'(k), 32'(k));
        check("sof_still_fill", 64'(a_ready), 64'd1);
        a_cycle(1'b1, 1'b0, 32'd511, 32'd511);
        check("sof_full_ready", 64'(a_ready), 64'd0);
        a_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        check("sof_full_frdy", 64'(a_frdy), 64'd1);
        a_rel = 1'b1;
        a_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        a_rel = 1'b0;

        // SOF_SYNC discard of non-SOF samples at position 0
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            a_cycle(1'b1, 1'b0, 32'(k), 32'(k));
            if (a_wrb !== 1'b0) errs++;
        end
        check("disc_no_wrb", 64'(errs), 64'd0);
        a_cycle(1'b1, 1'b1, 32'h77, 32'h66);
        check("disc_sof_wrb", 64'(a_wrb), 64'd1);
        check("disc_sof_addr", 64'(a_waddr), 64'd0);
        check("sof_err_sticky", 64'(a_serr), 64'd1);
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_clears_serr", 64'(a_serr), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Natural order, LOG2N = 4, gapped valid; release outside FULL ignored
        b_rel = 1'b1;
        @(negedge clk); #1;
        b_rel = 1'b0;
        check("b_rel_in_fill_ready", 64'(b_ready), 64'd1);
        check("b_rel_in_fill_wrb", 64'(b_wrb), 64'd0);
        wcnt = 0; s = 0; bad_addr = 0; bad_data = 0; bad_hi = 0;
        for (int c = 0; c < 60; c++) begin
            b_valid = (c % 3 == 0);
            b_sof   = b_valid && (s == 0);
            b_re    = 32'(100 + s);
            b_im    = 32'(s);
            if (b_valid && b_ready) s++;
            @(negedge clk); #1;
            if (b_wrb === 1'b1) begin
                if (b_waddr !== 9'(wcnt)) bad_addr++;
                if (b_di !== {32'(wcnt), 32'(100 + wcnt)}) bad_data++;
                wcnt++;
            end
            if (b_waddr[8:4] !== 5'd0) bad_hi++;
        end
        b_valid = 1'b0;
        check("nat_wrb_count", 64'(wcnt), 64'd16);
        check("nat_addr_order", 64'(bad_addr), 64'd0);
        check("nat_data", 64'(bad_data), 64'd0);
        check("nat_addr_hi_zero", 64'(bad_hi), 64'd0);
        check("nat_frdy", 64'(b_frdy), 64'd1);
        check("nat_ready", 64'(b_ready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
